// File: rtl/uart_rx_fifo_writer_if.sv
// Bundles the receive strobe, full flag, overflow clear and the FIFO write-side outputs of
// uart_rx_fifo_writer. The controller uses the master modport; the environment uses slave.
interface uart_rx_fifo_writer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OVF_CNT_W  = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  comp_full;
  logic                  clr_ovf;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] w_add;
  logic                  hold_busy;
  logic                  ovf_flag;
  logic [OVF_CNT_W-1:0]  ovf_cnt;

  modport master (
    input  rx_data, rx_valid, comp_full, clr_ovf,
    output wr_en, wr_data, w_add, hold_busy, ovf_flag, ovf_cnt
  );

  modport slave (
    output rx_data, rx_valid, comp_full, clr_ovf,
    input  wr_en, wr_data, w_add, hold_busy, ovf_flag, ovf_cnt
  );
endinterface

// File: rtl/uart_rx_fifo_writer.sv
// Write-side controller of the UART->processor async FIFO (uart_clk domain): writes received
// bytes, parks one byte while the FIFO is full, and counts bytes dropped beyond that.
module uart_rx_fifo_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OVF_CNT_W  = 8
) (
  input  logic                  uart_clk,
  input  logic                  reset,
  uart_rx_fifo_writer_if.master bus
);
  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure, so each byte is written,
  // parked or dropped in the cycle it arrives; wr_en is a one-cycle write strobe with no ready,
  // addressed by the pre-increment w_add.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_q,    state_d;
  logic [DATA_WIDTH-1:0] hold_q,     hold_d;
  logic                  wr_en_q,    wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q,  wr_data_d;
  logic [ADDR_WIDTH-1:0] w_add_q,    w_add_d;
  logic                  ovf_flag_q, ovf_flag_d;
  logic [OVF_CNT_W-1:0]  ovf_cnt_q,  ovf_cnt_d;
  logic                  drop;

  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      w_add_q    <= '0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      w_add_q    <= w_add_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    w_add_d   = wr_en_q ? ADDR_WIDTH'(w_add_q + 1'b1) : w_add_q;
    drop      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (!bus.comp_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.rx_data;
          end else begin
            hold_d  = bus.rx_data;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.comp_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = hold_q;
          // A byte arriving as room opens takes the freed hold slot rather than being written.
          if (bus.rx_valid) hold_d  = bus.rx_data;
          else              state_d = IDLE;
        end else if (bus.rx_valid) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as clr_ovf counts from a cleared counter.
    ovf_flag_d = bus.clr_ovf ? 1'b0 : ovf_flag_q;
    ovf_cnt_d  = bus.clr_ovf ? '0   : ovf_cnt_q;
    if (drop) begin
      ovf_flag_d = 1'b1;
      if (bus.clr_ovf)      ovf_cnt_d = OVF_CNT_W'(1);
      else if (!(&ovf_cnt_q)) ovf_cnt_d = OVF_CNT_W'(ovf_cnt_q + 1'b1);
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.w_add     = w_add_q;
  assign bus.hold_busy = (state_q == HOLD);
  assign bus.ovf_flag  = ovf_flag_q;
  assign bus.ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer: cycle vector table plus hand-written corner
// sequences, with a write scoreboard of expected {address, data} pairs.
module tb_uart_rx_fifo_writer;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CW = 8;

  logic uart_clk = 1'b0;
  logic reset    = 1'b1;

  uart_rx_fifo_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_CNT_W(CW)) bus();

  uart_rx_fifo_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OVF_CNT_W(CW)) dut (
    .uart_clk (uart_clk),
    .reset    (reset),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 uart_clk = ~uart_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    exp_ptr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f, input logic c);
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.comp_full = f;
    bus.clr_ovf   = c;
  endtask

  task automatic tick();
    @(posedge uart_clk);
    #1;
  endtask

  task automatic expect_write(input logic [DW-1:0] d);
    exp_q.push_back({exp_ptr, d});
    exp_ptr = exp_ptr + 1'b1;
  endtask

  task automatic apply_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_ptr = '0;
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [DW-1:0] wd,
                            input logic hb, input logic of, input logic [CW-1:0] oc);
    chk({tag, ".wr_en"},     32'(bus.wr_en),     32'(we));
    chk({tag, ".wr_data"},   32'(bus.wr_data),   32'(wd));
    chk({tag, ".hold_busy"}, 32'(bus.hold_busy), 32'(hb));
    chk({tag, ".ovf_flag"},  32'(bus.ovf_flag),  32'(of));
    chk({tag, ".ovf_cnt"},   32'(bus.ovf_cnt),   32'(oc));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge uart_clk) begin
    if (!reset && bus.wr_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 32'({bus.w_add, bus.wr_data}), 32'hFFFF_FFFF);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_write", 32'({bus.w_add, bus.wr_data}), 32'(e));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          f;
    logic          c;
    logic          we;
    logic [DW-1:0] wd;
    logic          hb;
    logic          of;
    logic [CW-1:0] oc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic v, input logic [DW-1:0] d, input logic f, input logic c,
                     input logic we, input logic [DW-1:0] wd, input logic hb,
                     input logic of, input logic [CW-1:0] oc);
    vec_t r;
    r = '{v, d, f, c, we, wd, hb, of, oc};
    vq.push_back(r);
  endtask

  initial begin
    // park 0x3C, hold for 5 full cycles, then release
    add(1, 8'h3C, 1, 0,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 1, 0,  0, 8'h00, 1, 0, 0);
    add(0, 8'h00, 0, 0,  1, 8'h3C, 0, 0, 0);
    add(0, 8'h00, 0, 0,  0, 8'h3C, 0, 0, 0);
    // park 0x5A then three drops; held byte still written intact
    add(1, 8'h5A, 1, 0,  0, 8'h3C, 1, 0, 0);
    add(1, 8'h11, 1, 0,  0, 8'h3C, 1, 1, 1);
    add(1, 8'h22, 1, 0,  0, 8'h3C, 1, 1, 2);
    add(1, 8'h33, 1, 0,  0, 8'h3C, 1, 1, 3);
    add(0, 8'h00, 0, 0,  1, 8'h5A, 0, 1, 3);
    add(0, 8'h00, 0, 0,  0, 8'h5A, 0, 1, 3);
    // full falls together with rx_valid 0x77: held byte then 0x77, no drop
    add(1, 8'hC3, 1, 0,  0, 8'h5A, 1, 1, 3);
    add(1, 8'h77, 0, 0,  1, 8'hC3, 1, 1, 3);
    add(0, 8'h00, 0, 0,  1, 8'h77, 0, 1, 3);
    add(0, 8'h00, 0, 0,  0, 8'h77, 0, 1, 3);
    // clear alone, then clear coincident with a drop
    add(0, 8'h00, 0, 1,  0, 8'h77, 0, 0, 0);
    add(1, 8'h81, 1, 0,  0, 8'h77, 1, 0, 0);
    add(1, 8'h82, 1, 0,  0, 8'h77, 1, 1, 1);
    add(1, 8'h83, 1, 0,  0, 8'h77, 1, 1, 2);
    add(1, 8'h84, 1, 1,  0, 8'h77, 1, 1, 1);
    add(0, 8'h00, 1, 1,  0, 8'h77, 1, 0, 0);
  end

  // ---------------- main sequence ----------------
  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    check_outs("reset", 0, 8'h00, 0, 0, 0);
    chk("reset.w_add", 32'(bus.w_add), 32'd0);
    reset = 1'b0;
    #1;

    // single byte: written next cycle at address 0, pointer advances after
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    expect_write(8'hA5);
    tick();
    chk("t1.wr_en", 32'(bus.wr_en), 32'd1);
    chk("t1.wr_data", 32'(bus.wr_data), 32'hA5);
    chk("t1.w_add", 32'(bus.w_add), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t1.wr_en_after", 32'(bus.wr_en), 32'd0);
    chk("t1.w_add_after", 32'(bus.w_add), 32'd1);
    tick();
    chk("t1.sb_empty", 32'(exp_q.size()), 32'd0);

    // 16 back-to-back bytes: addresses 0..15, pointer wraps to 0
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0);
      expect_write(DW'(i));
      tick();
      chk("t2.w_add", 32'(bus.w_add), 32'(i));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk("t2.w_add_wrap", 32'(bus.w_add), 32'd0);
    chk("t2.ovf_flag", 32'(bus.ovf_flag), 32'd0);
    tick();
    chk("t2.sb_empty", 32'(exp_q.size()), 32'd0);

    // table-driven hold / drop / clear cycles
    apply_reset();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].d, vq[i].f, vq[i].c);
      if (vq[i].we) expect_write(vq[i].wd);
      tick();
      check_outs($sformatf("vec%0d", i), vq[i].we, vq[i].wd, vq[i].hb, vq[i].of, vq[i].oc);
    end
    chk("vec.w_add", 32'(bus.w_add), 32'(exp_ptr));
    chk("vec.sb_empty", 32'(exp_q.size()), 32'd0);

    // async reset mid-HOLD: outputs clear without a clock edge, parked byte lost
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_rst", 0, 8'h00, 0, 0, 0);
    chk("async_rst.w_add", 32'(bus.w_add), 32'd0);
    @(posedge uart_clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_ptr = '0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    check_outs("post_rst", 0, 8'h00, 0, 0, 0);
    chk("post_rst.w_add", 32'(bus.w_add), 32'd0);

    // drop counter saturates at all-ones; held byte still written
    drive(1'b1, 8'hE1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, DW'($urandom_range(0, 255)), 1'b1, 1'b0);
      tick();
    end
    chk("sat.ovf_cnt", 32'(bus.ovf_cnt), 32'hFF);
    chk("sat.ovf_flag", 32'(bus.ovf_flag), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    expect_write(8'hE1);
    tick();
    check_outs("sat.release", 1, 8'hE1, 0, 1, 8'hFF);
    tick();
    chk("sat.sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
